// File: rtl/friscv_pkg.sv
// Shared types for the FRiscV load/store path: data width, LSU op encoding,
// LSU state encoding and small address-qualification helpers.
package friscv_pkg;

  localparam int ARCH = 32;

  // {is_store, funct3}
  typedef enum logic [3:0] {
    LSU_LB  = 4'h0,
    LSU_LH  = 4'h1,
    LSU_LW  = 4'h2,
    LSU_LBU = 4'h4,
    LSU_LHU = 4'h5,
    LSU_SB  = 4'h8,
    LSU_SH  = 4'h9,
    LSU_SW  = 4'hA
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    case (op)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
      LSU_SB, LSU_SH, LSU_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Round the address down to the natural alignment of the access size.
  function automatic logic [ARCH-1:0] force_align(input logic [3:0] op,
                                                  input logic [ARCH-1:0] addr);
    case (op[1:0])
      2'b01:   return {addr[ARCH-1:1], 1'b0};
      2'b10:   return {addr[ARCH-1:2], 2'b00};
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and lane-shifted store
// data, plus load-data right-shift and sign/zero extension.
module lsu_align
  import friscv_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [1:0]      a_i,
  input  logic [ARCH-1:0] wdata_i,
  input  logic [ARCH-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [ARCH-1:0] wdata_o,
  output logic [ARCH-1:0] ldata_o
);

  logic [ARCH-1:0] shifted;

  // Store side: place data in its byte lane and enable only the lanes written.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i << {a_i, 3'b000};
    if (op_i[3]) begin
      case (op_i[1:0])
        2'b00:   be_o = 4'b0001 << a_i;
        2'b01:   be_o = 4'b0011 << a_i;
        default: be_o = 4'b1111;
      endcase
    end
  end

  // Load side: bring the addressed lane down to bit 0, then extend by size/sign.
  always_comb begin
    shifted = rdata_i >> {a_i, 3'b000};
    case (op_i[2:0])
      3'b000:  ldata_o = {{(ARCH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ldata_o = {{(ARCH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ldata_o = {{(ARCH-8){1'b0}}, shifted[7:0]};
      3'b101:  ldata_o = {{(ARCH-16){1'b0}}, shifted[15:0]};
      default: ldata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// FRiscV RV32I load/store unit: one data-memory transaction at a time over a
// req/gnt/rvalid bus. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// accesses into error responses; otherwise they are forced to natural alignment.
module lsu
  import friscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_in,
  input  logic            rstn_in,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [3:0]      req_op_in,
  input  logic [ARCH-1:0] req_addr_in,
  input  logic [ARCH-1:0] req_wdata_in,
  output logic            mem_req_out,
  input  logic            mem_gnt_in,
  output logic            mem_we_out,
  output logic [ARCH-1:0] mem_addr_out,
  output logic [3:0]      mem_be_out,
  output logic [ARCH-1:0] mem_wdata_out,
  input  logic            mem_rvalid_in,
  input  logic [ARCH-1:0] mem_rdata_in,
  output logic            rsp_valid_out,
  output logic [ARCH-1:0] rsp_data_out,
  output logic            rsp_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  lsu_state_t      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [ARCH-1:0] addr_q, addr_d;
  logic [ARCH-1:0] wdata_q, wdata_d;
  logic [ARCH-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]      be;
  logic [ARCH-1:0] wdata_lane;
  logic [ARCH-1:0] ldata;

  lsu_align u_align (
    .op_i    (op_q),
    .a_i     (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem_rdata_in),
    .be_o    (be),
    .wdata_o (wdata_lane),
    .ldata_o (ldata)
  );

  // State and transaction registers; async reset abandons any open transaction.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, bus handshake, read wait with timeout, respond.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          op_d    = req_op_in;
          wdata_d = req_wdata_in;
          data_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          addr_d  = req_addr_in;
          if (!op_is_valid(req_op_in) || misaligned(req_op_in, req_addr_in[1:0])) begin
`else
          addr_d  = force_align(req_op_in, req_addr_in);
          if (!op_is_valid(req_op_in)) begin
`endif
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_in) begin
          cnt_d   = '0;
          state_d = op_q[3] ? DONE : WAIT;
        end
      end
      WAIT: begin
        // rvalid takes priority over a timeout landing on the same cycle
        if (mem_rvalid_in) begin
          data_d  = ldata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_out = (state_q == IDLE);
  assign mem_req_out   = (state_q == REQ);
  assign mem_we_out    = (state_q == REQ) && op_q[3];
  assign mem_addr_out  = (state_q == REQ) ? {addr_q[ARCH-1:2], 2'b00} : '0;
  assign mem_be_out    = (state_q == REQ) ? be : 4'b0000;
  assign mem_wdata_out = (state_q == REQ) ? wdata_lane : '0;
  assign rsp_valid_out = (state_q == DONE);
  assign rsp_data_out  = (state_q == DONE) ? data_q : '0;
  assign rsp_err_out   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: loads, stores, stalls, timeout, bad op,
// misaligned handling and mid-transaction reset.
module tb_lsu;

  logic        clk_in;
  logic        rstn_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [3:0]  req_op_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        mem_req_out;
  logic        mem_gnt_in;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_wdata_out;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_data_out;
  logic        rsp_err_out;

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in        (clk_in),
    .rstn_in       (rstn_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_op_in     (req_op_in),
    .req_addr_in   (req_addr_in),
    .req_wdata_in  (req_wdata_in),
    .mem_req_out   (mem_req_out),
    .mem_gnt_in    (mem_gnt_in),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_be_out    (mem_be_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rvalid_in (mem_rvalid_in),
    .mem_rdata_in  (mem_rdata_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_err_out   (rsp_err_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the first negedge after accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_in = 1'b1;
    req_op_in    = op;
    req_addr_in  = addr;
    req_wdata_in = wdata;
    @(negedge clk_in);
    req_valid_in = 1'b0;
  endtask

  // Best-case load: gnt in first REQ cycle, rvalid in first WAIT cycle.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] exp_addr, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    issue(op, addr, 32'h0);
    check({tag, ".req"},  mem_req_out, 32'd1);
    check({tag, ".addr"}, mem_addr_out, exp_addr);
    check({tag, ".be"},   mem_be_out, 32'hF);
    check({tag, ".we"},   mem_we_out, 32'd0);
    mem_gnt_in = 1'b1;
    @(negedge clk_in);
    mem_gnt_in = 1'b0;
    check({tag, ".wait_noreq"}, mem_req_out, 32'd0);
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = rdata;
    @(negedge clk_in);
    mem_rvalid_in = 1'b0;
    check({tag, ".rsp_valid"}, rsp_valid_out, 32'd1);
    check({tag, ".rsp_data"},  rsp_data_out, exp_data);
    check({tag, ".rsp_err"},   rsp_err_out, 32'd0);
    @(negedge clk_in);
    check({tag, ".rsp_drop"}, rsp_valid_out, 32'd0);
    check({tag, ".ready"},    req_ready_out, 32'd1);
  endtask

  // Store with `stall` cycles of gnt held low before the grant.
  task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall,
                          input logic [31:0] exp_addr, input logic [31:0] exp_be,
                          input logic [31:0] exp_wdata);
    issue(op, addr, wdata);
    for (int i = 0; i <= stall; i++) begin
      check({tag, ".req"},   mem_req_out, 32'd1);
      check({tag, ".we"},    mem_we_out, 32'd1);
      check({tag, ".addr"},  mem_addr_out, exp_addr);
      check({tag, ".be"},    mem_be_out, exp_be);
      check({tag, ".wdata"}, mem_wdata_out, exp_wdata);
      check({tag, ".norsp"}, rsp_valid_out, 32'd0);
      if (i == stall) mem_gnt_in = 1'b1;
      @(negedge clk_in);
      mem_gnt_in = 1'b0;
    end
    check({tag, ".rsp_valid"}, rsp_valid_out, 32'd1);
    check({tag, ".rsp_err"},   rsp_err_out, 32'd0);
    check({tag, ".rsp_data"},  rsp_data_out, 32'd0);
    @(negedge clk_in);
    check({tag, ".rsp_drop"}, rsp_valid_out, 32'd0);
  endtask

  initial begin
    int k;
    rstn_in       = 1'b1;
    req_valid_in  = 1'b0;
    req_op_in     = 4'h0;
    req_addr_in   = 32'h0;
    req_wdata_in  = 32'h0;
    mem_gnt_in    = 1'b0;
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = 32'h0;
    #1 rstn_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("rst.ready", req_ready_out, 32'd1);
    check("rst.mreq",  mem_req_out, 32'd0);
    check("rst.rsp",   rsp_valid_out, 32'd0);
    check("rst.data",  rsp_data_out, 32'd0);
    check("rst.err",   rsp_err_out, 32'd0);
    rstn_in = 1'b1;
    @(negedge clk_in);

    // Loads with lane selection and extension
    do_load("lb",  4'h0, 32'h0000_0103, 32'h0000_0100, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load("lhu", 4'h5, 32'h0000_0202, 32'h0000_0200, 32'hBEEF_1234, 32'h0000_BEEF);
    do_load("lh",  4'h1, 32'h0000_0010, 32'h0000_0010, 32'h0000_8001, 32'hFFFF_8001);
    do_load("lbu", 4'h4, 32'h0000_0021, 32'h0000_0020, 32'h0000_9A00, 32'h0000_009A);
    do_load("lw",  4'h2, 32'h0000_0400, 32'h0000_0400, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Stores: SB with grant stalled 3 cycles, SH upper half, SW aligned
    do_store("sb", 4'h8, 32'h0000_0001, 32'h0000_00AB, 3, 32'h0, 32'h2, 32'h0000_AB00);
    do_store("sh", 4'h9, 32'h0000_0502, 32'h0000_BEEF, 0, 32'h0000_0500, 32'hC, 32'hBEEF_0000);

    // Misaligned SW
`ifdef LSU_MISALIGN_TRAP_EN
    issue(4'hA, 32'h0000_0006, 32'h1122_3344);
    check("sw_mis.noreq", mem_req_out, 32'd0);
    check("sw_mis.rsp",   rsp_valid_out, 32'd1);
    check("sw_mis.err",   rsp_err_out, 32'd1);
    check("sw_mis.data",  rsp_data_out, 32'd0);
    @(negedge clk_in);
`else
    do_store("sw_mis", 4'hA, 32'h0000_0006, 32'h1122_3344, 0, 32'h0000_0004, 32'hF, 32'h1122_3344);
`endif

    // Undefined op: immediate error response, no bus access
    issue(4'h3, 32'h0000_0040, 32'h0);
    check("badop.noreq", mem_req_out, 32'd0);
    check("badop.rsp",   rsp_valid_out, 32'd1);
    check("badop.err",   rsp_err_out, 32'd1);
    @(negedge clk_in);

    // LW timeout: count WAIT cycles until the response
    issue(4'h2, 32'h0000_0800, 32'h0);
    mem_gnt_in = 1'b1;
    @(negedge clk_in);
    mem_gnt_in = 1'b0;
    k = 0;
    while (!rsp_valid_out && k < 40) begin
      k++;
      @(negedge clk_in);
    end
    check("tmo.wait_cycles", k, 32'd16);
    check("tmo.rsp", rsp_valid_out, 32'd1);
    check("tmo.err", rsp_err_out, 32'd1);
    check("tmo.data", rsp_data_out, 32'd0);
    @(negedge clk_in);

    // rvalid on the final WAIT cycle beats the timeout
    issue(4'h2, 32'h0000_0300, 32'h0);
    mem_gnt_in = 1'b1;
    @(negedge clk_in);
    mem_gnt_in = 1'b0;
    repeat (15) @(negedge clk_in);
    check("race.still_wait", rsp_valid_out, 32'd0);
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'h1234_5678;
    @(negedge clk_in);
    mem_rvalid_in = 1'b0;
    check("race.rsp",  rsp_valid_out, 32'd1);
    check("race.err",  rsp_err_out, 32'd0);
    check("race.data", rsp_data_out, 32'h1234_5678);
    @(negedge clk_in);

    // Reset while in REQ
    issue(4'h2, 32'h0000_0900, 32'h0);
    check("rstreq.req", mem_req_out, 32'd1);
    #2 rstn_in = 1'b0;
    #1;
    check("rstreq.mreq",  mem_req_out, 32'd0);
    check("rstreq.ready", req_ready_out, 32'd1);
    @(negedge clk_in);
    rstn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("rstreq.norsp", rsp_valid_out, 32'd0);
    end
    check("rstreq.ready_after", req_ready_out, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
